// File: rtl/cache_sa_param.sv
`default_nettype none
// ============================================================================
// cache_sa_param : write-through, write-allocate N-way set-associative cache
//                  with round-robin replacement, set-serial flush and stats.
// Revision: 1.0
// ============================================================================
module cache_sa_param #(
    parameter int SETS       = 32,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    input  logic        i_flush,
    output logic        o_busy,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [3:0]  i_req_mask,
    input  logic [31:0] i_req_wdata,
    output logic [31:0] o_res_rdata,
    output logic [31:0] o_stat_hits,
    output logic [31:0] o_stat_misses
);
    localparam int OFF = $clog2(LINE_WORDS) + 2;
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 32 - IDX - OFF;
    localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WDB = $clog2(LINE_WORDS);
    localparam int ICB = WDB + 1;
    localparam logic [ICB-1:0] LW_C     = ICB'(LINE_WORDS);
    localparam logic [WDB-1:0] LAST_W   = WDB'(LINE_WORDS - 1);
    localparam logic [IDX-1:0] LAST_SET = IDX'(SETS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_RESP  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    logic [31:0]     r_data  [SETS][WAYS][LINE_WORDS];
    logic [TAG-1:0]  r_tag   [SETS][WAYS];
    logic [WAYS-1:0] r_valid [SETS];
    logic [WB-1:0]   r_rr    [SETS];

    logic [31:0]     r_addr, r_wdata, r_hits, r_misses;
    logic [3:0]      r_mask;
    logic            r_is_write, r_vvalid, r_flush_pend;
    logic [WB-1:0]   r_way;
    logic [ICB-1:0]  r_issue;
    logic [WDB-1:0]  r_resp;
    logic [IDX-1:0]  r_fset;

    logic [31:0]     w_addr, w_wdata, w_bmask, w_line_word, w_merged, w_ddata;
    logic [3:0]      w_mask;
    logic [TAG-1:0]  w_tag;
    logic [IDX-1:0]  w_set;
    logic [WDB-1:0]  w_word, w_dword;
    logic [WB-1:0]   w_hit_way, w_victim, w_way;
    logic            w_hit, w_all_valid, w_flush_go;
    logic            w_hit_inc, w_miss_inc, w_dwe, w_latch, w_fill_start;
    logic            w_unused_ok;

    // Outside IDLE the hart may drop its request, so the latched copy is used.
    assign w_addr  = (r_state == S_IDLE) ? i_req_addr  : r_addr;
    assign w_mask  = (r_state == S_IDLE) ? i_req_mask  : r_mask;
    assign w_wdata = (r_state == S_IDLE) ? i_req_wdata : r_wdata;
    assign w_tag   = w_addr[31:IDX+OFF];
    assign w_set   = w_addr[IDX+OFF-1:OFF];
    assign w_word  = w_addr[OFF-1:2];
    assign w_bmask = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
    assign w_way   = (r_state == S_IDLE) ? w_hit_way : r_way;
    assign w_line_word = r_data[w_set][w_way][w_word];
    assign w_merged    = (w_line_word & ~w_bmask) | (w_wdata & w_bmask);
    assign w_all_valid = &r_valid[w_set];
    assign w_flush_go  = i_flush | r_flush_pend;
    assign w_unused_ok = ^w_addr[1:0];

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WB'(w);
            end
        end
    end

    // Descending scan so the lowest-index invalid way wins over the pointer.
    always_comb begin
        w_victim = (WAYS > 1) ? r_rr[w_set] : '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_set][w]) w_victim = WB'(w);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_busy       = 1'b0;
        o_mem_ren    = 1'b0;
        o_mem_wen    = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_res_rdata  = '0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_dwe        = 1'b0;
        w_ddata      = w_merged;
        w_dword      = w_word;
        w_latch      = 1'b0;
        w_fill_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_flush_go) begin
                    o_busy      = i_req_ren | i_req_wen;
                    w_state_nxt = S_FLUSH;
                end else if (i_req_ren || i_req_wen) begin
                    if (w_hit) begin
                        w_hit_inc = 1'b1;
                        if (i_req_ren) begin
                            o_res_rdata = w_line_word & w_bmask;
                        end else if (i_mem_ready) begin
                            o_mem_wen   = 1'b1;
                            o_mem_addr  = i_req_addr;
                            o_mem_wdata = w_merged;
                            w_dwe       = 1'b1;
                        end else begin
                            o_busy      = 1'b1;
                            w_latch     = 1'b1;
                            w_state_nxt = S_WRITE;
                        end
                    end else begin
                        o_busy       = 1'b1;
                        w_miss_inc   = 1'b1;
                        w_latch      = 1'b1;
                        w_fill_start = 1'b1;
                        w_state_nxt  = S_FILL;
                    end
                end
            end
            S_FILL: begin
                o_busy = 1'b1;
                if (r_issue < LW_C) begin
                    o_mem_ren  = 1'b1;
                    o_mem_addr = {r_addr[31:OFF], r_issue[WDB-1:0], 2'b00};
                end
                if (i_mem_valid) begin
                    w_dwe   = 1'b1;
                    w_dword = r_resp;
                    w_ddata = i_mem_rdata;
                    if (r_resp == LAST_W) w_state_nxt = r_is_write ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: begin
                o_busy = 1'b1;
                if (i_mem_ready) begin
                    o_mem_wen   = 1'b1;
                    o_mem_addr  = r_addr;
                    o_mem_wdata = w_merged;
                    w_dwe       = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (!r_is_write) o_res_rdata = w_line_word & w_bmask;
                w_state_nxt = S_IDLE;
            end
            S_FLUSH: begin
                o_busy = 1'b1;
                if (r_fset == LAST_SET) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_dwe) r_data[w_set][w_way][w_dword] <= w_ddata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_flush_pend <= 1'b0;
            r_hits       <= '0;
            r_misses     <= '0;
            r_issue      <= '0;
            r_resp       <= '0;
            r_fset       <= '0;
            r_addr       <= '0;
            r_mask       <= '0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
            r_way        <= '0;
            r_vvalid     <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_hit_inc && (r_hits != '1))    r_hits   <= r_hits + 32'd1;
            if (w_miss_inc && (r_misses != '1)) r_misses <= r_misses + 32'd1;
            if (r_state != S_IDLE && i_flush) r_flush_pend <= 1'b1;
            else if (r_state == S_IDLE)       r_flush_pend <= 1'b0;
            if (w_latch) begin
                r_addr     <= i_req_addr;
                r_mask     <= i_req_mask;
                r_wdata    <= i_req_wdata;
                r_is_write <= i_req_wen;
                r_way      <= w_fill_start ? w_victim : w_hit_way;
            end
            if (w_fill_start) begin
                r_valid[w_set][w_victim] <= 1'b0;
                r_tag[w_set][w_victim]   <= w_tag;
                r_vvalid                 <= w_all_valid;
                r_issue                  <= '0;
                r_resp                   <= '0;
            end
            if (r_state == S_FILL) begin
                if (o_mem_ren && i_mem_ready) r_issue <= r_issue + 1'b1;
                if (i_mem_valid) begin
                    r_resp <= r_resp + 1'b1;
                    if (r_resp == LAST_W) begin
                        r_valid[w_set][r_way] <= 1'b1;
                        if (WAYS > 1 && r_vvalid) r_rr[w_set] <= r_way + 1'b1;
                    end
                end
            end
            if (r_state == S_IDLE && w_flush_go) r_fset <= '0;
            if (r_state == S_FLUSH) begin
                r_valid[r_fset] <= '0;
                r_rr[r_fset]    <= '0;
                r_fset          <= r_fset + 1'b1;
            end
        end
    end

    assign o_stat_hits   = r_hits;
    assign o_stat_misses = r_misses;

endmodule
`default_nettype wire
